// File: rtl/uart_irq_ctrl_if.sv
// uart_irq_ctrl_if -- signal bundle between a UART register block and its
// interrupt controller.
//
// Signals (direction as seen by the controller, i.e. the slave modport):
//   enable16      in   16x baud-rate strobe (one cycle wide)
//   char_bits     in   frame length in bit periods, legal 7..12
//   ier           in   enables: [0] RDA/TO, [1] THRE, [2] RLS, [3] MS
//   rx_level_hit  in   level, RX FIFO at/above trigger level
//   rx_count_nz   in   level, RX FIFO non-empty
//   rx_push       in   pulse, byte written into RX FIFO
//   rx_pop        in   pulse, byte read from RX FIFO
//   line_err      in   pulse, overrun/parity/framing/break seen
//   lsr_read      in   pulse, line status register read
//   msr_read      in   pulse, modem status register read
//   iir_read      in   pulse, interrupt identification register read
//   thr_write     in   pulse, transmit holding register written
//   thr_empty     in   level, transmit holding register/FIFO empty
//   msr_change    in   pulse, modem status delta
//   IRQ           out  registered interrupt request, active high
//   iir           out  registered interrupt identification code
//
// The master modport is the register-block side that drives the events and
// observes the interrupt outputs.

interface uart_irq_ctrl_if;
  logic       enable16;
  logic [3:0] char_bits;
  logic [3:0] ier;
  logic       rx_level_hit;
  logic       rx_count_nz;
  logic       rx_push;
  logic       rx_pop;
  logic       line_err;
  logic       lsr_read;
  logic       msr_read;
  logic       iir_read;
  logic       thr_write;
  logic       thr_empty;
  logic       msr_change;
  logic       IRQ;
  logic [3:0] iir;

  modport master (
    output enable16,
    output char_bits,
    output ier,
    output rx_level_hit,
    output rx_count_nz,
    output rx_push,
    output rx_pop,
    output line_err,
    output lsr_read,
    output msr_read,
    output iir_read,
    output thr_write,
    output thr_empty,
    output msr_change,
    input  IRQ,
    input  iir
  );

  modport slave (
    input  enable16,
    input  char_bits,
    input  ier,
    input  rx_level_hit,
    input  rx_count_nz,
    input  rx_push,
    input  rx_pop,
    input  line_err,
    input  lsr_read,
    input  msr_read,
    input  iir_read,
    input  thr_write,
    input  thr_empty,
    input  msr_change,
    output IRQ,
    output iir
  );
endinterface

// File: rtl/uart_irq_ctrl.sv
// uart_irq_ctrl -- 16550-style UART interrupt controller.
//
// Tracks the pending state of the receive-line-status, modem-status and
// transmit-holding-empty sources, takes received-data-available as a level,
// optionally runs a character timeout counter, and registers the highest
// priority enabled source as an IIR code plus an IRQ line.
//
// Ports:
//   CLK    in   sole clock, everything on the rising edge
//   RESET  in   synchronous active-high reset
//   bus    slave modport of uart_irq_ctrl_if (event inputs, IRQ/iir outputs)
//
// Configuration:
//   UART_IRQ_TIMEOUT_EN  defined   -> 10-bit character timeout counter and
//                                     the TO source (IIR 1100) are built.
//                        undefined -> no counter, TO never reported;
//                                     enable16/char_bits/rx_push/rx_pop/
//                                     rx_count_nz are ignored.
//
// Timing: pending flags and the IIR register update on the same edge; the
// priority encoder looks at next-state pending values, so an event sampled
// on edge N is visible on iir/IRQ right after edge N.

module uart_irq_ctrl (
  input logic            CLK,
  input logic            RESET,
  uart_irq_ctrl_if.slave bus
);

  localparam logic [3:0] IirRls  = 4'b0110;
  localparam logic [3:0] IirRda  = 4'b0100;
  localparam logic [3:0] IirTo   = 4'b1100;
  localparam logic [3:0] IirThre = 4'b0010;
  localparam logic [3:0] IirMs   = 4'b0000;
  localparam logic [3:0] IirNone = 4'b0001;

  logic       rls_pend_q, rls_pend_d;
  logic       ms_pend_q, ms_pend_d;
  logic       thre_pend_q, thre_pend_d;
  logic       thr_empty_q;
  logic [3:0] ier_q;
  logic [3:0] iir_q, iir_d;
  logic       irq_q;

  logic       rda_src;
  logic       to_pend_d;
  logic       thre_set;
  logic       thre_clr;

  // ---------------------------------------------------------------------------
  // Latched sources: set has priority over clear within a cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    rls_pend_d = rls_pend_q;
    if (bus.lsr_read) begin
      rls_pend_d = 1'b0;
    end
    if (bus.line_err) begin
      rls_pend_d = 1'b1;
    end
  end

  always_comb begin
    ms_pend_d = ms_pend_q;
    if (bus.msr_read) begin
      ms_pend_d = 1'b0;
    end
    if (bus.msr_change) begin
      ms_pend_d = 1'b1;
    end
  end

  // THRE arms on a fresh empty edge, or when software enables THRE while the
  // holder is already empty. Reading IIR only acknowledges it if THRE is what
  // IIR is showing right now.
  always_comb begin
    thre_set = (bus.thr_empty && !thr_empty_q) ||
               (bus.ier[1] && !ier_q[1] && bus.thr_empty);
    thre_clr = bus.thr_write || (bus.iir_read && (iir_q == IirThre));
    thre_pend_d = thre_pend_q;
    if (thre_clr) begin
      thre_pend_d = 1'b0;
    end
    if (thre_set) begin
      thre_pend_d = 1'b1;
    end
  end

  // Received data available is a pure level from the FIFO.
  assign rda_src = bus.rx_level_hit;

  // ---------------------------------------------------------------------------
  // Character timeout
  // ---------------------------------------------------------------------------
`ifdef UART_IRQ_TIMEOUT_EN
  logic [9:0] to_cnt_q, to_cnt_d;
  logic [3:0] eff_bits;
  logic [9:0] to_limit;

  // Out-of-range frame lengths fall back to the longest legal frame.
  always_comb begin
    if ((bus.char_bits >= 4'd7) && (bus.char_bits <= 4'd12)) begin
      eff_bits = bus.char_bits;
    end else begin
      eff_bits = 4'd12;
    end
  end

  // 64 * char_bits: four character times at 16 ticks per bit.
  assign to_limit = {eff_bits, 6'b00_0000};

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (bus.rx_push || bus.rx_pop || !bus.rx_count_nz) begin
      to_cnt_d = '0;
    end else if (bus.enable16 && (to_cnt_q < to_limit)) begin
      to_cnt_d = to_cnt_q + 10'd1;
    end
  end

  assign to_pend_d = bus.rx_count_nz && (to_cnt_d == to_limit);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout_inputs;
  assign unused_timeout_inputs = ^{bus.enable16, bus.char_bits, bus.rx_push,
                                   bus.rx_pop, bus.rx_count_nz};
  assign to_pend_d = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Priority encoder, gated by the live ier so masking takes effect at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    iir_d = IirNone;
    if (bus.ier[2] && rls_pend_d) begin
      iir_d = IirRls;
    end else if (bus.ier[0] && rda_src) begin
      iir_d = IirRda;
    end else if (bus.ier[0] && to_pend_d) begin
      iir_d = IirTo;
    end else if (bus.ier[1] && thre_pend_d) begin
      iir_d = IirThre;
    end else if (bus.ier[3] && ms_pend_d) begin
      iir_d = IirMs;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rls_pend_q  <= 1'b0;
      ms_pend_q   <= 1'b0;
      thre_pend_q <= 1'b0;
      thr_empty_q <= 1'b0;
      ier_q       <= 4'b0000;
      iir_q       <= IirNone;
      irq_q       <= 1'b0;
    end else begin
      rls_pend_q  <= rls_pend_d;
      ms_pend_q   <= ms_pend_d;
      thre_pend_q <= thre_pend_d;
      thr_empty_q <= bus.thr_empty;
      ier_q       <= bus.ier;
      iir_q       <= iir_d;
      irq_q       <= (iir_d != IirNone);
    end
  end

  assign bus.iir = iir_q;
  assign bus.IRQ = irq_q;

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// tb_uart_irq_ctrl -- directed scenarios followed by randomized traffic,
// each cycle compared against a behavioural interrupt model.

module tb_uart_irq_ctrl;

  logic CLK = 1'b0;
  logic RESET;

  uart_irq_ctrl_if bus ();

  uart_irq_ctrl dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;

  // Reference model state
  bit       m_rls;
  bit       m_ms;
  bit       m_thre;
  bit       m_thr_prev;
  bit [3:0] m_ier_prev;
  bit [3:0] m_iir = 4'b0001;
`ifdef UART_IRQ_TIMEOUT_EN
  int       m_cnt;

  function automatic int lim_of(int cb);
    return 64 * (((cb >= 7) && (cb <= 12)) ? cb : 12);
  endfunction
`endif

  task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
    checks++;
    assert (got === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Advances the model by one clock edge using the inputs sampled at that edge.
  task automatic model_update();
    bit       to;
    bit       set_t;
    bit       clr_t;
    bit [3:0] ier;
    ier = bus.ier;
    to  = 1'b0;
    if (RESET) begin
      m_rls = 0; m_ms = 0; m_thre = 0; m_thr_prev = 0; m_ier_prev = 0;
      m_iir = 4'b0001;
`ifdef UART_IRQ_TIMEOUT_EN
      m_cnt = 0;
`endif
    end else begin
      if (bus.line_err) m_rls = 1; else if (bus.lsr_read) m_rls = 0;
      if (bus.msr_change) m_ms = 1; else if (bus.msr_read) m_ms = 0;
      set_t = (bus.thr_empty && !m_thr_prev) || (ier[1] && !m_ier_prev[1] && bus.thr_empty);
      clr_t = bus.thr_write || (bus.iir_read && m_iir == 4'b0010);
      if (set_t) m_thre = 1; else if (clr_t) m_thre = 0;
`ifdef UART_IRQ_TIMEOUT_EN
      if (bus.rx_push || bus.rx_pop || !bus.rx_count_nz) m_cnt = 0;
      else if (bus.enable16 && m_cnt < lim_of(int'(bus.char_bits))) m_cnt++;
      to = bus.rx_count_nz && (m_cnt == lim_of(int'(bus.char_bits)));
`endif
      m_thr_prev = bus.thr_empty;
      m_ier_prev = ier;
      if (ier[2] && m_rls)                 m_iir = 4'b0110;
      else if (ier[0] && bus.rx_level_hit) m_iir = 4'b0100;
      else if (ier[0] && to)               m_iir = 4'b1100;
      else if (ier[1] && m_thre)           m_iir = 4'b0010;
      else if (ier[3] && m_ms)             m_iir = 4'b0000;
      else                                 m_iir = 4'b0001;
    end
  endtask

  // One clock: update model at the edge, compare just after, then clear pulses.
  task automatic tick(string tag);
    @(posedge CLK);
    model_update();
    #1;
    chk({tag, "_iir"}, bus.iir, m_iir);
    chk({tag, "_irq"}, {3'b000, bus.IRQ}, {3'b000, (m_iir != 4'b0001)});
    @(negedge CLK);
    bus.rx_push = 0; bus.rx_pop = 0; bus.line_err = 0; bus.lsr_read = 0;
    bus.msr_read = 0; bus.iir_read = 0; bus.thr_write = 0; bus.msr_change = 0;
    RESET = 0;
  endtask

  task automatic do_reset();
    RESET = 1;
    tick("reset");
  endtask

  initial begin
    RESET = 1;
    bus.enable16 = 0; bus.char_bits = 4'd10; bus.ier = 4'b0000;
    bus.rx_level_hit = 0; bus.rx_count_nz = 0; bus.rx_push = 0; bus.rx_pop = 0;
    bus.line_err = 0; bus.lsr_read = 0; bus.msr_read = 0; bus.iir_read = 0;
    bus.thr_write = 0; bus.thr_empty = 0; bus.msr_change = 0;
    @(negedge CLK);

    // Reset state
    do_reset();
    chk("rst_iir", bus.iir, 4'b0001);
    chk("rst_irq", {3'b000, bus.IRQ}, 4'b0000);

    // RLS over RDA, then RDA once RLS is acknowledged
    bus.ier = 4'b0101; bus.rx_level_hit = 1; bus.line_err = 1;
    tick("rls");
    chk("rls_code", bus.iir, 4'b0110);
    chk("rls_irq", {3'b000, bus.IRQ}, 4'b0001);
    bus.lsr_read = 1;
    tick("rda");
    chk("rda_code", bus.iir, 4'b0100);
    bus.rx_level_hit = 0;
    tick("rda_off");

    // THRE on empty edge, acknowledged by IIR read, not re-raised by held level
    do_reset();
    bus.ier = 4'b0010; bus.thr_empty = 0;
    tick("thre_idle");
    bus.thr_empty = 1;
    tick("thre_set");
    chk("thre_code", bus.iir, 4'b0010);
    chk("thre_irq", {3'b000, bus.IRQ}, 4'b0001);
    bus.iir_read = 1;
    tick("thre_ack");
    chk("thre_ack_code", bus.iir, 4'b0001);
    chk("thre_ack_irq", {3'b000, bus.IRQ}, 4'b0000);
    for (int i = 0; i < 4; i++) tick("thre_hold");
    chk("thre_hold_code", bus.iir, 4'b0001);
    // Re-enabling THRE while already empty re-arms it; masking hides but keeps it
    bus.ier = 4'b0000;
    tick("thre_mask");
    bus.ier = 4'b0010;
    tick("thre_rearm");
    chk("thre_rearm_code", bus.iir, 4'b0010);
    bus.ier = 4'b0000;
    tick("thre_masked");
    chk("thre_masked_code", bus.iir, 4'b0001);
    bus.thr_write = 1; bus.thr_empty = 0;
    tick("thre_write");

    // MS set and clear together: set wins
    do_reset();
    bus.ier = 4'b1000; bus.msr_change = 1; bus.msr_read = 1;
    tick("ms_both");
    chk("ms_code", bus.iir, 4'b0000);
    chk("ms_irq", {3'b000, bus.IRQ}, 4'b0001);
    tick("ms_hold");
    bus.msr_read = 1;
    tick("ms_clear");

    // Character timeout (or its absence)
    do_reset();
    bus.ier = 4'b0001; bus.char_bits = 4'd10; bus.rx_count_nz = 1;
    bus.rx_level_hit = 0; bus.enable16 = 1;
    for (int i = 0; i < 639; i++) tick("to_run");
    chk("to_639", bus.iir, 4'b0001);
    tick("to_640");
`ifdef UART_IRQ_TIMEOUT_EN
    chk("to_fire", bus.iir, 4'b1100);
    chk("to_fire_irq", {3'b000, bus.IRQ}, 4'b0001);
`else
    chk("to_absent", bus.iir, 4'b0001);
    chk("to_absent_irq", {3'b000, bus.IRQ}, 4'b0000);
`endif
    bus.rx_pop = 1;
    tick("to_pop");
    chk("to_pop_code", bus.iir, 4'b0001);

    // Reset with everything pending and the counter part-way
    do_reset();
    bus.ier = 4'b1111; bus.thr_empty = 0;
    for (int i = 0; i < 300; i++) tick("mid_run");
    bus.line_err = 1; bus.msr_change = 1; bus.thr_empty = 1; bus.rx_level_hit = 1;
    tick("mid_pend");
    bus.line_err = 1; bus.msr_change = 1; bus.lsr_read = 0;
    RESET = 1;
    tick("mid_reset");
    chk("mid_reset_code", bus.iir, 4'b0001);
    chk("mid_reset_irq", {3'b000, bus.IRQ}, 4'b0000);
    bus.ier = 4'b0001; bus.rx_level_hit = 0;
    for (int i = 0; i < 639; i++) tick("mid_rerun");
    chk("mid_639", bus.iir, 4'b0001);
    tick("mid_640");
`ifdef UART_IRQ_TIMEOUT_EN
    chk("mid_fire", bus.iir, 4'b1100);
`else
    chk("mid_absent", bus.iir, 4'b0001);
`endif

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bus.line_err   = ($urandom_range(31) == 0);
      bus.lsr_read   = ($urandom_range(15) == 0);
      bus.msr_change = ($urandom_range(31) == 0);
      bus.msr_read   = ($urandom_range(15) == 0);
      bus.iir_read   = ($urandom_range(7) == 0);
      bus.thr_write  = ($urandom_range(15) == 0);
      bus.rx_push    = ($urandom_range(1023) == 0);
      bus.rx_pop     = ($urandom_range(1023) == 0);
      bus.enable16   = ($urandom_range(7) != 0);
      if ($urandom_range(15) == 0) bus.thr_empty = ~bus.thr_empty;
      if ($urandom_range(63) == 0) bus.ier = 4'($urandom_range(15));
      if ($urandom_range(63) == 0) bus.rx_level_hit = ~bus.rx_level_hit;
      if ($urandom_range(255) == 0) bus.rx_count_nz = ~bus.rx_count_nz;
      if ($urandom_range(511) == 0) bus.char_bits = 4'($urandom_range(15));
      RESET = ($urandom_range(1023) == 0);
      tick("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_irq_ctrl.md
UART_IRQ_CTRL -- requirements
Module: uart_irq_ctrl

Interface
REQ-001 SHALL have port: CLK  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have port: RESET  in  1  synchronous active-high reset.
REQ-003 SHALL have port: enable16  in  1  one-cycle strobe at 16x baud rate.
REQ-004 SHALL have port: char_bits  in  4  frame length in bit periods (start+data+parity+stop), legal 7..12.
REQ-005 SHALL have port: ier  in  4  enables: [0] RDA, [1] THRE, [2] RLS, [3] MS.
REQ-006 SHALL have port: rx_level_hit  in  1  level, RX FIFO at/above trigger level.
REQ-007 SHALL have port: rx_count_nz  in  1  level, RX FIFO non-empty.
REQ-008 SHALL have port: rx_push / rx_pop  in  1 each  pulses, byte written to / read from RX FIFO.
REQ-009 SHALL have port: line_err  in  1  pulse, overrun/parity/framing/break detected.
REQ-010 SHALL have port: lsr_read, msr_read, iir_read, thr_write  in  1 each  register-access pulses.
REQ-011 SHALL have port: thr_empty  in  1  level, transmit holding register/FIFO empty.
REQ-012 SHALL have port: msr_change  in  1  pulse, modem status delta.
REQ-013 SHALL have port: IRQ  out  1  registered interrupt request, active high.
REQ-014 SHALL have port: iir  out  4  registered interrupt identification code.

Function
REQ-015 rls_pend SHALL set on line_err and clear on lsr_read; set wins over clear in the same cycle.
REQ-016 ms_pend SHALL set on msr_change and clear on msr_read; set wins over clear.
REQ-017 rda_src SHALL equal rx_level_hit (level, no latch).
REQ-018 thre_pend SHALL set on rising edge of thr_empty, or on ier[1] 0->1 while thr_empty=1; clears on thr_write, or on iir_read when iir currently reads 0010; set wins over clear.
REQ-019 Timeout counter (10 bits) SHALL clear on rx_push, rx_pop, or rx_count_nz=0, else increment on enable16, saturating at limit = 64*char_bits.
REQ-020 to_pend SHALL be 1 while counter equals limit and rx_count_nz=1; clears via counter clear (rx_pop/rx_push).
REQ-021 Priority (highest first) with ier gating: RLS (ier[2]) 0110, RDA (ier[0]) 0100, TO (ier[0]) 1100, THRE (ier[1]) 0010, MS (ier[3]) 0000; none 0001.
REQ-022 iir and IRQ SHALL register the prioritized result: one cycle latency from pending-state change; IRQ = (iir != 0001).
REQ-023 Clearing ier bit SHALL mask the source within one cycle but SHALL NOT clear its pending flag (except THRE re-arm per REQ-018).
REQ-024 char_bits outside 7..12 SHALL be treated as 12.

Reset
REQ-025 On RESET=1 at a clock edge: rls_pend, ms_pend, thre_pend, counter, registered thr_empty/ier history = 0; iir = 0001; IRQ = 0.
REQ-026 RESET mid-timeout count SHALL discard the count; counting restarts from 0 after release.
REQ-027 RESET SHALL override every set/clear input in the same cycle.

Configuration
REQ-028 Macro UART_IRQ_TIMEOUT_EN defined: timeout counter and TO source (1100) present per REQ-019/020.
REQ-029 Macro undefined: counter absent, to_pend tied 0, iir never 1100; enable16 and char_bits ignored; all other behaviour unchanged.

Verification
REQ-030 ier=0101, line_err pulse with rx_level_hit=1 -> next cycle iir=0110, IRQ=1; lsr_read -> iir=0100 next cycle.
REQ-031 ier=0010, thr_empty 0->1 -> iir=0010, IRQ=1; iir_read -> iir=0001, IRQ=0 next cycle; thr_empty held 1 does not re-raise.
REQ-032 (UART_IRQ_TIMEOUT_EN) ier=0001, char_bits=10, rx_count_nz=1, rx_level_hit=0, no push/pop -> iir=1100 one cycle after 640th enable16; rx_pop -> iir=0001.
REQ-033 msr_change and msr_read same cycle, ier=1000 -> ms_pend stays set, iir=0000, IRQ=1.
REQ-034 RESET asserted with all sources pending and counter at 300 -> iir=0001, IRQ=0 next cycle; timeout needs full 64*char_bits ticks again.
REQ-035 Macro undefined, same stimulus as REQ-032 -> iir stays 0001, IRQ=0.
